// File: rtl/cpu_controller.sv
// Eight-phase fetch/decode/execute sequencer for the 5-bit-address accumulator CPU.
// Optional halt-resume support is compiled in with `define CPU_CTRL_RESUME_EN.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef CPU_CTRL_RESUME_EN
  input  logic       resume,
`endif
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;

  typedef enum logic [2:0] {
    HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
  } op_t;

  phase_t state;
  logic   halted;
  logic   wake;
  logic   alu_op;
  op_t    op;

  assign op     = op_t'(opcode);
  assign alu_op = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  assign phase  = state;

`ifdef CPU_CTRL_RESUME_EN
  assign wake = resume;
`else
  assign wake = 1'b0;
`endif

  // Halting freezes the counter at OP_ADDR; resuming skips straight to OP_FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else if (halted) begin
      if (wake) begin
        halted <= 1'b0;
        state  <= OP_FETCH;
      end
    end else if (state == OP_ADDR && op == HLT) begin
      halted <= 1'b1;
    end else begin
      state <= phase_t'(state + 3'd1);
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted) begin
      halt   = 1'b1;
      // The resume cycle steps the PC past the HLT instruction.
      inc_pc = wake;
    end else begin
      unique case (state)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR:    inc_pc = (op != HLT);
        OP_FETCH:   rd = alu_op;
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (op == SKZ) && zero;
          ld_pc  = (op == JMP);
          data_e = (op == STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (op == JMP);
          wr     = (op == STO);
          data_e = (op == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: phase/halt reference model plus an emulated PC
// checked against per-instruction program-counter arithmetic.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
  logic [2:0] phase;
`ifdef CPU_CTRL_RESUME_EN
  logic       resume;
`endif

  int errors = 0;
  int checks = 0;

  int         mph;
  bit         mhalt;
  logic [4:0] bpc;
  logic [4:0] epc;
  logic [4:0] cur_addr;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
`ifdef CPU_CTRL_RESUME_EN
    .resume(resume),
`endif
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output vector order: sel rd ld_ir halt inc_pc ld_pc ld_ac wr data_e
  function automatic logic [8:0] expect_out(input int ph, input bit hlt,
                                            input logic [2:0] op, input logic z,
                                            input logic res);
    logic alu, s, r, ir, h, inc, lpc, lac, w, de;
    alu = (op >= 3'd2) && (op <= 3'd5);
    s = 0; r = 0; ir = 0; h = 0; inc = 0; lpc = 0; lac = 0; w = 0; de = 0;
    if (hlt) begin
      h = 1;
`ifdef CPU_CTRL_RESUME_EN
      inc = res;
`endif
    end else begin
      s   = (ph <= 3);
      r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      ir  = (ph == 2 || ph == 3);
      inc = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z);
      lpc = (ph >= 6 && op == 3'd7);
      lac = (ph == 7 && alu);
      w   = (ph == 7 && op == 3'd6);
      de  = (ph >= 6 && op == 3'd6);
    end
    return {s, r, ir, h, inc, lpc, lac, w, de};
  endfunction

  task automatic check_outputs(input logic [2:0] op, input logic z, input logic res);
    check("strobes", {sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e},
          expect_out(mph, mhalt, op, z, res));
    check("phase", phase, mph);
    check("pc_excl", inc_pc & ld_pc, 0);
    check("wr_data_e", wr & ~data_e, 0);
  endtask

  // One clock: drive inputs at edge+1, check at edge+3, emulate PC, advance model.
  task automatic cycle(input logic [2:0] op, input logic z, input logic res);
    opcode = op;
    zero   = z;
`ifdef CPU_CTRL_RESUME_EN
    resume = res;
`endif
    #2;
    check_outputs(op, z, res);
    if (ld_pc) bpc = cur_addr;
    else if (inc_pc) bpc = bpc + 5'd1;
    @(posedge clk);
    #1;
    if (mhalt) begin
`ifdef CPU_CTRL_RESUME_EN
      if (res) begin
        mhalt = 0;
        mph   = 5;
      end
`endif
    end else if (mph == 4 && op == 3'd0) begin
      mhalt = 1;
    end else begin
      mph = (mph + 1) % 8;
    end
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input logic [4:0] addr);
    check("pc", bpc, epc);
    cur_addr = addr;
    for (int i = 0; i < 8; i++)
      cycle(op, (mph == 6) ? z : 1'($urandom), 1'b0);
    if (op == 3'd1 && z) epc = epc + 5'd2;
    else if (op == 3'd7) epc = addr;
    else epc = epc + 5'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mph = 0;
    mhalt = 0;
    check_outputs(3'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs(3'($urandom), 1'b0, 1'b0);
    rst = 1'b0;
    bpc = '0;
    epc = '0;
  endtask

  task automatic run_halt();
    check("pc", bpc, epc);
    for (int i = 0; i < 5; i++) cycle(3'd0, 1'($urandom), 1'b0);
    check("halted", int'(mhalt), 1);
    for (int i = 0; i < 22; i++) cycle(3'($urandom), 1'($urandom), 1'b0);
`ifdef CPU_CTRL_RESUME_EN
    cycle(3'd0, 1'($urandom), 1'b1);
    epc = epc + 5'd1;
    for (int i = 0; i < 3; i++) cycle(3'd0, 1'($urandom), 1'b0);
`else
    do_reset();
`endif
  endtask

  initial begin
    rst = 1'b1;
    opcode = '0;
    zero = 1'b0;
`ifdef CPU_CTRL_RESUME_EN
    resume = 1'b0;
`endif
    mph = 0;
    mhalt = 0;
    bpc = '0;
    epc = '0;
    cur_addr = '0;
    #3;
    check_outputs(3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(3'd2, 1'b0, 5'd3);
    run_instr(3'd1, 1'b1, 5'd0);
    run_instr(3'd1, 1'b0, 5'd0);
    run_instr(3'd7, 1'b0, 5'b10101);
    check("jmp_pc", bpc, 5'b10101);
    run_instr(3'd6, 1'b1, 5'd9);
    for (int n = 0; n < 40; n++)
      run_instr(3'($urandom_range(1, 7)), 1'($urandom), 5'($urandom));

    for (int i = 0; i < 5; i++) cycle(3'd2, 1'($urandom), 1'b0);
    check("mid_phase", mph, 5);
    do_reset();

    run_instr(3'd4, 1'b0, 5'd1);
    run_halt();
    for (int n = 0; n < 10; n++)
      run_instr(3'($urandom_range(1, 7)), 1'($urandom), 5'($urandom));
    run_halt();
    run_instr(3'd5, 1'b1, 5'd7);
    check("pc", bpc, epc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Phase-sequencing controller for the 5-bit-address accumulator CPU. Steps through a fixed 8-phase fetch/decode/execute cycle and drives the strobes for the program counter (`inc_pc`, `ld_pc`), instruction register, accumulator and memory bus. It sits between the instruction register's opcode field and the PC/IR/AC/memory datapath. It is the only source of PC control in the design.

## Interface
- No parameters; phase count (8) and opcode width (3) are fixed.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  3  opcode field from the instruction register.
- `zero`  in  1  accumulator-is-zero flag.
- `resume`  in  1  leave halt state; present only with `CPU_CTRL_RESUME_EN`.
- `sel`  out  1  memory address mux: 1 = PC address, 0 = IR operand address.
- `rd`  out  1  memory read enable.
- `ld_ir`  out  1  load instruction register.
- `halt`  out  1  CPU halted.
- `inc_pc`  out  1  increment program counter.
- `ld_pc`  out  1  load PC from IR address field.
- `ld_ac`  out  1  load accumulator from ALU.
- `wr`  out  1  memory write strobe.
- `data_e`  out  1  drive accumulator onto data bus.
- `phase`  out  3  current phase, for debug and bench.

## Operation
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALUOP = ADD | AND | XOR | LDA.
- Phases (3-bit counter, +1 per clock, 7 wraps to 0):
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
- Outputs are combinational decode of `phase`, `opcode`, `zero` and the halted flag. Any output not listed for a phase is 0.
  - Phase 0: sel=1.
  - Phase 1: sel=1, rd=1.
  - Phases 2 and 3: sel=1, rd=1, ld_ir=1.
  - Phase 4: inc_pc=1 unless opcode=HLT.
  - Phase 5: rd=ALUOP.
  - Phase 6: rd=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
  - Phase 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- HLT handling:
  - In phase 4 with opcode=HLT, the halted flag sets on the next edge.
  - The phase counter then freezes at 4.
  - While halted: halt=1; inc_pc, ld_pc, ld_ac, wr, data_e, rd, ld_ir and sel are all 0.
  - The halted state persists until `rst`, or until `resume` when that feature is compiled in.
- Invariants (bench checks these):
  - `ld_pc` and `inc_pc` are never both 1.
  - `wr` is only ever 1 together with `data_e`.

## Timing
- Reset (async, immediate on `rst`): phase=0, halted=0. Resulting outputs: sel=1, all other strobes 0, halt=0, phase=000.
- First rising edge after `rst` deasserts moves to phase 1.
- One instruction takes exactly 8 clocks. The instruction word is latched by the edge ending phase 3.
- Strobe effects: `inc_pc`/`ld_pc` in phase N take effect on the PC at the edge ending phase N.
  - Normal instruction: PC advances once, at the end of phase 4.
  - SKZ with zero=1: second advance at the end of phase 6.
  - JMP: load at the end of phase 6; phase 7 reloads the same value.
- `zero` is sampled only during phase 6. `opcode` must be stable from phase 4 through 7.
- Reset asserted mid-instruction or mid-halt: immediate return to the reset state. No partial strobes after `rst` rises.

## Configuration
- `CPU_CTRL_RESUME_EN` defined:
  - `resume` port exists.
  - When halted and `resume`=1 at a rising edge: halted clears, phase goes to 5, and `inc_pc`=1 during that resume cycle (combinational on `resume` & halted) so the PC steps past the HLT.
  - `resume` is ignored when not halted.
- `CPU_CTRL_RESUME_EN` undefined: no `resume` port; halt exits only via `rst`.

## Test plan
- Reset: assert `rst` mid-phase 5. Required immediately: phase=0, sel=1, all other strobes 0, halt=0. After release, phase reads 1,2,…,7,0 on successive edges.
- ADD (opcode=010): phase 4 inc_pc=1; phases 5–7 rd=1; phase 7 ld_ac=1. wr, ld_pc, data_e stay 0. Exactly one inc_pc pulse per 8 clocks.
- SKZ (001): with zero=1, inc_pc pulses in phases 4 and 6 (PC +2 per instruction). With zero=0, only phase 4 (PC +1).
- JMP (111) with IR address 10101: ld_pc=1 in phases 6 and 7, inc_pc=0 in both. Paired PC module then reads 10101.
- STO (110): data_e=1 in phases 6–7, wr=1 only in phase 7, rd=0 in phases 5–7.
- HLT (000): at phase 4 inc_pc=0. From the next edge, halt=1, phase holds at 4 for 20+ clocks, all strobes 0.
  - With `CPU_CTRL_RESUME_EN`: a one-cycle `resume` pulse gives inc_pc=1 in that cycle, then phase=5, halt=0.
